// File: rtl/led_pkg.sv
// Shared constants for the APA102 LED string path.
// Frame types, header bits and default brightness.
package led_pkg;

  localparam logic [1:0] INPUT_TYPE_START = 2'd0;
  localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
  localparam logic [1:0] INPUT_TYPE_END   = 2'd2;

  localparam logic [2:0] LED_HDR    = 3'b111;
  localparam int         FRAME_BITS = 32;

  localparam logic [4:0] DEFAULT_BRIGHTNESS = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } ser_state_e;

endpackage

// File: rtl/apa102_spi_serializer.sv
// APA102 frame serializer: one START, LED or END frame
// per request, shifted MSB-first on mosi/sck.
module apa102_spi_serializer
  import led_pkg::*;
#(
  parameter int unsigned SCK_DIV    = 2,
  parameter logic [4:0]  BRIGHTNESS = DEFAULT_BRIGHTNESS,
  parameter int unsigned END_BITS   = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] type_input,
  input  logic [7:0] blue_input,
  input  logic [7:0] green_input,
  input  logic [7:0] red_input,
  input  logic       doled_start,
  output logic       doled_busy,
  output logic       mosi,
  output logic       sck
);

  localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);
  localparam logic [5:0] NB_STD   = 6'(FRAME_BITS);
  localparam logic [5:0] NB_END   = 6'(END_BITS);

  ser_state_e  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bits_q, bits_d;
  logic [31:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic [31:0] frame_word;
  logic        type_ok;

  // Build the candidate frame word from the current request inputs.
  always_comb begin
    frame_word = '0;
    type_ok    = 1'b1;
    unique case (type_input)
      INPUT_TYPE_START: frame_word = '0;
      INPUT_TYPE_LED:   frame_word = {LED_HDR, BRIGHTNESS, blue_input,
                                      green_input, red_input};
      INPUT_TYPE_END:   frame_word = '1;
      default:          type_ok    = 1'b0;
    endcase
  end

  // Next-state logic: accept in IDLE, then alternate LOW/HIGH per bit.
  // The word shifts in its own LSB so END keeps sending ones past bit 32.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    word_d  = word_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (doled_start && type_ok) begin
          word_d  = frame_word;
          bits_d  = (type_input == INPUT_TYPE_END) ? NB_END : NB_STD;
          busy_d  = 1'b1;
          mosi_d  = frame_word[31];
          sck_d   = 1'b0;
          div_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bits_q > 6'd1) begin
            word_d  = {word_q[30:0], word_q[0]};
            mosi_d  = word_q[30];
            bits_d  = bits_q - 6'd1;
            state_d = ST_LOW;
          end else begin
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            bits_d  = '0;
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign doled_busy = busy_q;
  assign sck        = sck_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_apa102_spi_serializer.sv
// Scoreboard bench for apa102_spi_serializer.
// Expected frames are built from the frame rules, checked by a monitor.
module tb_apa102_spi_serializer;

  localparam int DIV  = 2;
  localparam int EBIT = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] type_input = '0;
  logic [7:0] blue_input = '0;
  logic [7:0] green_input = '0;
  logic [7:0] red_input = '0;
  logic       doled_start = 1'b0;
  logic       doled_busy;
  logic       mosi;
  logic       sck;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] bits;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  bit   abandon = 0;

  apa102_spi_serializer #(
    .SCK_DIV(DIV),
    .BRIGHTNESS(5'h1F),
    .END_BITS(EBIT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .type_input(type_input),
    .blue_input(blue_input),
    .green_input(green_input),
    .red_input(red_input),
    .doled_start(doled_start),
    .doled_busy(doled_busy),
    .mosi(mosi),
    .sck(sck)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [1:0] t, input logic [7:0] b,
                                 input logic [7:0] g, input logic [7:0] r);
    exp_t e;
    e.bits = '0;
    e.n = 32;
    if (t == 2'd0) begin
      e.bits = 64'h0;
    end else if (t == 2'd1) begin
      e.bits = {32'h0, 8'hFF, b, g, r};
    end else begin
      e.n = EBIT;
      for (int i = 0; i < EBIT; i++) e.bits[i] = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: collect bits on rising sck, compare when busy falls.
  logic [63:0] m_bits = '0;
  int          m_nb = 0;
  int          m_cyc = 0;
  bit          m_merr = 0;
  logic        sck_p = 0, mosi_p = 0, busy_p = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (doled_busy) begin
        m_cyc++;
        if (sck && !sck_p) begin
          m_bits = {m_bits[62:0], mosi};
          m_nb++;
        end
        if (sck && sck_p && mosi !== mosi_p) m_merr = 1;
      end
      if (!doled_busy && busy_p) begin
        if (abandon) begin
          abandon = 0;
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("bit_count", m_nb, e.n);
          check("frame_bits", m_bits, e.bits);
          check("busy_cycles", m_cyc, e.n * 2 * DIV);
          check("mosi_stable_sck_high", m_merr, 0);
        end
        m_bits = '0;
        m_nb = 0;
        m_cyc = 0;
        m_merr = 0;
      end
      sck_p = sck;
      mosi_p = mosi;
      busy_p = doled_busy;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [1:0] t, input logic [7:0] b,
                         input logic [7:0] g, input logic [7:0] r);
    type_input = t;
    blue_input = b;
    green_input = g;
    red_input = r;
    doled_start = 1'b1;
    exp_q.push_back(model(t, b, g, r));
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!doled_busy && k < 20) begin
      tick();
      k++;
    end
    if (!doled_busy) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (doled_busy && k < 1000) begin
      tick();
      k++;
    end
    if (doled_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] b,
                      input logic [7:0] g, input logic [7:0] r);
    set_req(t, b, g, r);
    tick();
    wait_busy();
    doled_start = 1'b0;
    wait_idle();
    tick();
  endtask

  initial begin
    logic [1:0] rt;
    tick();
    check("reset_busy", doled_busy, 0);
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    RST = 1'b0;
    repeat (2) tick();

    // START frame
    send(2'd0, 8'h00, 8'h00, 8'h00);
    // LED b=FF g=00 r=5A
    send(2'd1, 8'hFF, 8'h00, 8'h5A);

    // Inputs changed right after acceptance must not affect the word
    set_req(2'd1, 8'hC3, 8'h12, 8'h34);
    tick();
    blue_input = 8'h00;
    type_input = 2'd2;
    wait_busy();
    doled_start = 1'b0;
    wait_idle();
    tick();

    // END frame with 40 bits
    send(2'd2, 8'h00, 8'h00, 8'h00);

    // Reserved type is ignored
    type_input = 2'd3;
    doled_start = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (doled_busy || sck) bad++;
      end
      check("reserved_type_idle", bad, 0);
    end
    doled_start = 1'b0;
    tick();

    // Back-to-back frames with doled_start held high
    set_req(2'd1, 8'h81, 8'h42, 8'h24);
    tick();
    wait_busy();
    type_input = 2'd1;
    blue_input = 8'h5E;
    green_input = 8'hA7;
    red_input = 8'h3C;
    exp_q.push_back(model(2'd1, 8'h5E, 8'hA7, 8'h3C));
    wait_idle();
    tick();
    check("b2b_gap_one_cycle", doled_busy, 1);
    doled_start = 1'b0;
    wait_idle();
    tick();

    // Reset in the middle of an LED frame (during bit 10)
    set_req(2'd1, 8'h11, 8'h22, 8'h33);
    tick();
    wait_busy();
    doled_start = 1'b0;
    repeat (9 * 2 * DIV + 1) tick();
    abandon = 1;
    exp_q.delete();
    RST = 1'b1;
    #1;
    check("async_rst_busy", doled_busy, 0);
    check("async_rst_sck", sck, 0);
    check("async_rst_mosi", mosi, 0);
    #1;
    RST = 1'b0;
    begin
      int edges = 0;
      logic prev = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (sck && !prev) edges++;
        prev = sck;
      end
      check("no_sck_after_reset", edges, 0);
    end
    abandon = 0;

    // Randomized frames
    for (int i = 0; i < 10; i++) begin
      rt = 2'($urandom_range(0, 2));
      send(rt, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
